// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: ALU op codes, opcodes,
// functs, FSM states and the datapath select encodings.
package mc_pkg;

  localparam logic [5:0] ALUOP_ADD  = 6'b100000;
  localparam logic [5:0] ALUOP_ADDU = 6'b100001;
  localparam logic [5:0] ALUOP_SUB  = 6'b100010;
  localparam logic [5:0] ALUOP_SLT  = 6'b101010;
  localparam logic [5:0] ALUOP_SLTU = 6'b101011;
  localparam logic [5:0] ALUOP_LUI  = 6'b110000;
  localparam logic [5:0] ALUOP_ANDI = 6'b110100;
  localparam logic [5:0] ALUOP_ORI  = 6'b110101;
  localparam logic [5:0] ALUOP_XORI = 6'b110110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [2:0] {
    ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_ERR
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_J, CL_JAL, CL_JR, CL_BEQ, CL_BNE, CL_IMM, CL_LW, CL_SW
  } cls_e;

  // EX-stage ALU setup travels with the class so the FSM never re-decodes.
  typedef struct packed {
    cls_e       cls;
    logic       legal;
    logic [5:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       ext_sign;
  } dec_t;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011,
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV, FUNCT_JR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_decode.sv
// Combinational opcode/funct decoder: instruction class, legality and the
// ALU setup used in EX.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o          = '0;
    dec_o.cls      = CL_IMM;
    dec_o.legal    = 1'b1;
    dec_o.alu_op   = ALUOP_ADD;
    dec_o.src_a    = SRCA_RS;
    dec_o.src_b    = SRCB_IMM;
    dec_o.ext_sign = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.cls      = (funct_i == FUNCT_JR) ? CL_JR : CL_R;
        dec_o.legal    = funct_legal(funct_i);
        dec_o.alu_op   = funct_i;
        dec_o.src_b    = SRCB_RT;
        dec_o.ext_sign = 1'b0;
        // Constant shifts take the shift amount on A instead of rs.
        if (funct_i == FUNCT_SLL || funct_i == FUNCT_SRL || funct_i == FUNCT_SRA)
          dec_o.src_a = SRCA_SHAMT;
      end
      OP_J:     dec_o.cls = CL_J;
      OP_JAL:   dec_o.cls = CL_JAL;
      OP_BEQ, OP_BNE: begin
        dec_o.cls    = (opcode_i == OP_BEQ) ? CL_BEQ : CL_BNE;
        dec_o.alu_op = ALUOP_SUB;
        dec_o.src_b  = SRCB_RT;
      end
      OP_ADDI:  dec_o.alu_op = ALUOP_ADD;
      OP_ADDIU: dec_o.alu_op = ALUOP_ADDU;
      OP_SLTI:  dec_o.alu_op = ALUOP_SLT;
      OP_SLTIU: dec_o.alu_op = ALUOP_SLTU;
      OP_ANDI:  begin dec_o.alu_op = ALUOP_ANDI; dec_o.ext_sign = 1'b0; end
      OP_ORI:   begin dec_o.alu_op = ALUOP_ORI;  dec_o.ext_sign = 1'b0; end
      OP_XORI:  begin dec_o.alu_op = ALUOP_XORI; dec_o.ext_sign = 1'b0; end
      OP_LUI:   begin dec_o.alu_op = ALUOP_LUI;  dec_o.ext_sign = 1'b0; end
      OP_LW:    dec_o.cls = CL_LW;
      OP_SW:    dec_o.cls = CL_SW;
      default:  dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS sequencer: IF/ID/EX/MEM/WB/ERR state machine driving the
// shared ALU, operand selects and every write enable.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       eq,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [5:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   illegal_q;
  dec_t   dec;

  mc_decode u_dec (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec)
  );

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_FOUR;
    ext_sign   = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    wb_sel     = WB_ALU;
    instr_done = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        alu_src_b = SRCB_IMMSH;
        ext_sign  = 1'b1;
        if (!dec.legal) state_d = ST_ERR;
        else begin
          case (dec.cls)
            CL_J, CL_JAL: begin
              pc_we      = 1'b1;
              pc_src     = PCSRC_JUMP;
              instr_done = 1'b1;
              state_d    = ST_IF;
              if (dec.cls == CL_JAL) begin
                reg_we  = 1'b1;
                reg_dst = DST_RA;
                wb_sel  = WB_PC;
              end
            end
            CL_JR: begin
              pc_we      = 1'b1;
              pc_src     = PCSRC_RS;
              instr_done = 1'b1;
              state_d    = ST_IF;
            end
            default: state_d = ST_EX;
          endcase
        end
      end
      ST_EX: begin
        alu_op    = dec.alu_op;
        alu_src_a = dec.src_a;
        alu_src_b = dec.src_b;
        ext_sign  = dec.ext_sign;
        case (dec.cls)
          CL_BEQ, CL_BNE: begin
            // Target was parked in ALUOut during ID.
            pc_we      = (dec.cls == CL_BEQ) ? eq : !eq;
            pc_src     = PCSRC_ALUOUT;
            instr_done = 1'b1;
            state_d    = ST_IF;
          end
          CL_LW, CL_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec.cls == CL_SW) && mem_ready;
        if (mem_ready) begin
          if (dec.cls == CL_SW) begin
            instr_done = 1'b1;
            state_d    = ST_IF;
          end else state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (dec.cls == CL_R) ? DST_RD : DST_RT;
        wb_sel     = (dec.cls == CL_LW) ? WB_MDR : WB_ALU;
        instr_done = 1'b1;
        state_d    = ST_IF;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
    // Nothing may write while reset is held, even mid-instruction.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == ST_ERR);
    end
  end

  assign illegal = illegal_q;

endmodule
